// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and SRAM control/address pins of mem_arbiter.
// slave  = the arbiter itself.
// master = the surrounding world (fetch, memory stage and SRAM side).
// The SRAM data bus is a plain inout port on the arbiter so that it resolves as a real tri-state net.
interface mem_arbiter_if;
  logic        if_mc_en;
  logic [31:0] if_mc_addr;
  logic [31:0] mc_if_data;
  logic        mc_if_ack;
  logic        mem_mc_en;
  logic        mem_mc_rw;
  logic [31:0] mem_mc_addr;
  logic [31:0] mem_mc_wdata;
  logic [31:0] mc_mem_rdata;
  logic        mc_mem_ack;
  logic [17:0] mc_ram_addr;
  logic        mc_ram_we_n;
  logic        mc_ram_oe_n;
  logic        mc_ram_ce_n;
  logic        mc_ram_ub_n;
  logic        mc_ram_lb_n;

  modport slave (
    input  if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_wdata,
    output mc_if_data, mc_if_ack, mc_mem_rdata, mc_mem_ack,
    output mc_ram_addr, mc_ram_we_n, mc_ram_oe_n, mc_ram_ce_n, mc_ram_ub_n, mc_ram_lb_n
  );

  modport master (
    output if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_wdata,
    input  mc_if_data, mc_if_ack, mc_mem_rdata, mc_mem_ack,
    input  mc_ram_addr, mc_ram_we_n, mc_ram_oe_n, mc_ram_ce_n, mc_ram_ub_n, mc_ram_lb_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit SRAM between fetch (read-only) and the memory stage (read/write).
// Each granted request moves one 32-bit word as two halves: LO (bits [15:0]) then HI (bits [31:16]).
// Optional feature macro ARB_RR_EN: when defined, simultaneous requests alternate (round-robin);
// when undefined, the memory stage always wins a tie.
// WAIT_CYCLES (legal 1..15) sets the we_n-low / read-settle time of each half.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  mem_arbiter_if.slave bus,
  inout  wire  [15:0] mc_ram_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  // Each phase lasts WAIT_LOAD+1 cycles: the counter is loaded on entry and the phase ends at zero.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]  state_r;
  logic [3:0]  cnt_r;
  logic        gnt_mem_r;
  logic        rw_r;
  logic [16:0] addr_r;
  logic [31:0] wdata_r;
  logic [15:0] rd_lo_r;
  logic [15:0] dout_r;
  logic        drive_r;
  logic [31:0] if_data_r;
  logic [31:0] mem_rdata_r;
  logic        if_ack_r;
  logic        mem_ack_r;
  logic [17:0] ram_addr_r;
  logic        we_n_r;
  logic        oe_n_r;
  logic        ce_n_r;
  logic        bmask_n_r;

  logic        grant_s;
  logic        pick_mem_s;
  logic        grant_write_s;
  logic [16:0] sel_addr_s;
  logic        addr_unused_s;

`ifdef ARB_RR_EN
  logic        last_mem_r;

  // Remember which requester was granted last so that a tie goes to the other one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_mem_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && grant_s) begin
      last_mem_r <= pick_mem_s;
    end else begin
      last_mem_r <= last_mem_r;
    end
  end
`endif

  // Arbitrate between the two requesters and select the granted address.
  always_comb begin
    grant_s    = 1'b0;
    pick_mem_s = 1'b0;
    if (bus.mem_mc_en && bus.if_mc_en) begin
      grant_s = 1'b1;
`ifdef ARB_RR_EN
      pick_mem_s = ~last_mem_r;
`else
      pick_mem_s = 1'b1;
`endif
    end else if (bus.mem_mc_en) begin
      grant_s    = 1'b1;
      pick_mem_s = 1'b1;
    end else if (bus.if_mc_en) begin
      grant_s    = 1'b1;
      pick_mem_s = 1'b0;
    end else begin
      grant_s    = 1'b0;
      pick_mem_s = 1'b0;
    end
    sel_addr_s    = pick_mem_s ? bus.mem_mc_addr[18:2] : bus.if_mc_addr[18:2];
    grant_write_s = pick_mem_s & bus.mem_mc_rw;
  end

  // Byte-offset and out-of-range address bits are intentionally ignored.
  assign addr_unused_s = ^{bus.if_mc_addr[31:19], bus.if_mc_addr[1:0],
                           bus.mem_mc_addr[31:19], bus.mem_mc_addr[1:0]};

  // Sequence IDLE -> LO -> HI -> ACK, driving the SRAM strobes and assembling read halves.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      gnt_mem_r   <= 1'b0;
      rw_r        <= 1'b0;
      addr_r      <= 17'd0;
      wdata_r     <= 32'd0;
      rd_lo_r     <= 16'd0;
      dout_r      <= 16'd0;
      drive_r     <= 1'b0;
      if_data_r   <= 32'd0;
      mem_rdata_r <= 32'd0;
      if_ack_r    <= 1'b0;
      mem_ack_r   <= 1'b0;
      ram_addr_r  <= 18'd0;
      we_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      ce_n_r      <= 1'b1;
      bmask_n_r   <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if_ack_r  <= 1'b0;
          mem_ack_r <= 1'b0;
          if (grant_s) begin
            // Everything the access needs is captured here; requester inputs are ignored afterwards.
            state_r    <= ST_LO;
            cnt_r      <= WAIT_LOAD;
            gnt_mem_r  <= pick_mem_s;
            rw_r       <= grant_write_s;
            addr_r     <= sel_addr_s;
            wdata_r    <= bus.mem_mc_wdata;
            dout_r     <= bus.mem_mc_wdata[15:0];
            drive_r    <= grant_write_s;
            ram_addr_r <= {sel_addr_s, 1'b0};
            we_n_r     <= 1'b1;
            oe_n_r     <= grant_write_s;
            ce_n_r     <= 1'b0;
            bmask_n_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LO, ST_HI: begin
          if (cnt_r != 4'd0) begin
            // First cycle of a write phase is address/data setup; we_n falls after it.
            cnt_r  <= cnt_r - 4'd1;
            we_n_r <= ~rw_r;
          end else if (state_r == ST_LO) begin
            state_r    <= ST_HI;
            cnt_r      <= WAIT_LOAD;
            ram_addr_r <= {addr_r, 1'b1};
            dout_r     <= wdata_r[31:16];
            we_n_r     <= 1'b1;
            if (!rw_r) begin
              rd_lo_r <= mc_ram_data;
            end else begin
              rd_lo_r <= rd_lo_r;
            end
          end else begin
            state_r   <= ST_ACK;
            we_n_r    <= 1'b1;
            oe_n_r    <= 1'b1;
            ce_n_r    <= 1'b1;
            bmask_n_r <= 1'b1;
            drive_r   <= 1'b0;
            if (gnt_mem_r) begin
              mem_ack_r <= 1'b1;
              if (!rw_r) begin
                mem_rdata_r <= {mc_ram_data, rd_lo_r};
              end else begin
                mem_rdata_r <= mem_rdata_r;
              end
            end else begin
              if_ack_r  <= 1'b1;
              if_data_r <= {mc_ram_data, rd_lo_r};
            end
          end
        end
        ST_ACK: begin
          if_ack_r  <= 1'b0;
          mem_ack_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          if_ack_r  <= 1'b0;
          mem_ack_r <= 1'b0;
          we_n_r    <= 1'b1;
          oe_n_r    <= 1'b1;
          ce_n_r    <= 1'b1;
          bmask_n_r <= 1'b1;
          drive_r   <= 1'b0;
        end
      endcase
    end
  end

  assign mc_ram_data      = drive_r ? dout_r : 16'hzzzz;
  assign bus.mc_if_data   = if_data_r;
  assign bus.mc_if_ack    = if_ack_r;
  assign bus.mc_mem_rdata = mem_rdata_r;
  assign bus.mc_mem_ack   = mem_ack_r;
  assign bus.mc_ram_addr  = ram_addr_r;
  assign bus.mc_ram_we_n  = we_n_r;
  assign bus.mc_ram_oe_n  = oe_n_r;
  assign bus.mc_ram_ce_n  = ce_n_r;
  assign bus.mc_ram_ub_n  = bmask_n_r;
  assign bus.mc_ram_lb_n  = bmask_n_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed steps plus randomized rounds against a word-level reference model
// (service order, completion cycle, SRAM contents) for mem_arbiter.
module tb_mem_arbiter;
  localparam int unsigned W = 1;
  localparam int L = 2 * (W + 1) + 1;

  logic        clk;
  logic        rst_n;
  wire  [15:0] ram_data;
  logic        probe;
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] sram    [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [31:0] exp_if_data;
  logic [31:0] exp_mem_rdata;
  logic        last_mem;
  int          compared;
  int          mismatched;

  mem_arbiter_if bus ();

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .bus         (bus),
    .mc_ram_data (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM device: drives on read, stores on write-enable cycles; probe forces 0 to detect a stray driver.
  assign ram_data = (!bus.mc_ram_ce_n && !bus.mc_ram_oe_n) ? sram[bus.mc_ram_addr[9:0]] : 16'hzzzz;
  assign ram_data = probe ? 16'h0000 : 16'hzzzz;

  always @(posedge clk) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (!bus.mc_ram_ce_n && !bus.mc_ram_we_n) sram[bus.mc_ram_addr[9:0]] <= ram_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {ref_mem[{a[10:2], 1'b1}], ref_mem[{a[10:2], 1'b0}]};
  endfunction

  function automatic logic [31:0] strobes();
    return 32'({bus.mc_ram_we_n, bus.mc_ram_oe_n, bus.mc_ram_ce_n, bus.mc_ram_ub_n, bus.mc_ram_lb_n});
  endfunction

  task automatic check_released(input string tag);
    probe = 1'b1;
    #1;
    check(tag, 32'(ram_data), 32'h0);
    probe = 1'b0;
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [15:0] val);
    @(negedge clk);
    pl_addr = idx; pl_data = val; pl_en = 1'b1;
    ref_mem[idx] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One round: fetch and/or memory request raised together; the model predicts order, timing and data.
  task automatic run_round(input logic f, input logic m, input logic [31:0] fa, input logic [31:0] ma,
                           input logic mrw, input logic [31:0] mwd);
    logic        mem_first;
    logic        do_mem;
    int          t_if;
    int          t_mem;
    logic [31:0] e_if;
    logic [31:0] e_mem;
    if (f && m) begin
`ifdef ARB_RR_EN
      mem_first = !last_mem;
`else
      mem_first = 1'b1;
`endif
    end else begin
      mem_first = m;
    end
    t_if = 0; t_mem = 0;
    if (f && m) begin
      if (mem_first) begin t_mem = L; t_if = 2 * L + 1; end
      else begin t_if = L; t_mem = 2 * L + 1; end
    end else if (m) t_mem = L;
    else if (f) t_if = L;
    e_if = exp_if_data; e_mem = exp_mem_rdata;
    for (int k = 0; k < 2; k++) begin
      do_mem = (k == 0) ? mem_first : !mem_first;
      if (do_mem && m) begin
        if (mrw) begin
          ref_mem[{ma[10:2], 1'b0}] = mwd[15:0];
          ref_mem[{ma[10:2], 1'b1}] = mwd[31:16];
        end else begin
          e_mem = word(ma);
        end
      end else if (!do_mem && f) begin
        e_if = word(fa);
      end
    end
    if (f && m) last_mem = !mem_first;
    else if (m) last_mem = 1'b1;
    else if (f) last_mem = 1'b0;

    @(negedge clk);
    if (f) begin bus.if_mc_addr = fa; bus.if_mc_en = 1'b1; end
    if (m) begin
      bus.mem_mc_addr = ma; bus.mem_mc_rw = mrw; bus.mem_mc_wdata = mwd; bus.mem_mc_en = 1'b1;
    end
    for (int c = 1; c <= 2 * L + 3; c++) begin
      @(negedge clk);
      check("if_ack", 32'(bus.mc_if_ack), 32'(c == t_if));
      check("mem_ack", 32'(bus.mc_mem_ack), 32'(c == t_mem));
      if (bus.mc_if_ack) begin
        check("if_data", bus.mc_if_data, e_if);
        bus.if_mc_en = 1'b0;
      end
      if (bus.mc_mem_ack) begin
        check("mem_rdata", bus.mc_mem_rdata, e_mem);
        bus.mem_mc_en = 1'b0;
      end
      // Mid-transaction changes on a single active requester must not matter.
      if (c == 2 && !(f && m)) begin
        bus.if_mc_addr   = $urandom;
        bus.mem_mc_addr  = $urandom;
        bus.mem_mc_rw    = 1'($urandom_range(0, 1));
        bus.mem_mc_wdata = $urandom;
      end
    end
    bus.if_mc_en = 1'b0; bus.mem_mc_en = 1'b0;
    exp_if_data = e_if; exp_mem_rdata = e_mem;
    if (m && mrw) begin
      check("sram_lo", 32'(sram[{ma[10:2], 1'b0}]), 32'(ref_mem[{ma[10:2], 1'b0}]));
      check("sram_hi", 32'(sram[{ma[10:2], 1'b1}]), 32'(ref_mem[{ma[10:2], 1'b1}]));
    end
  endtask

  initial begin
    logic        rf;
    logic        rm;
    int          sel;
    compared = 0; mismatched = 0;
    probe = 1'b0; pl_en = 1'b0; pl_addr = 10'd0; pl_data = 16'd0;
    rst_n = 1'b0;
    bus.if_mc_en = 1'b0; bus.if_mc_addr = 32'd0;
    bus.mem_mc_en = 1'b0; bus.mem_mc_rw = 1'b0; bus.mem_mc_addr = 32'd0; bus.mem_mc_wdata = 32'd0;
    exp_if_data = 32'd0; exp_mem_rdata = 32'd0; last_mem = 1'b0;

    // Fill the SRAM with random contents while the arbiter is held in reset.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pl_addr = 10'(i); pl_data = 16'($urandom); pl_en = 1'b1;
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;

    // Reset values.
    check("rst_if_ack", 32'(bus.mc_if_ack), 32'd0);
    check("rst_mem_ack", 32'(bus.mc_mem_ack), 32'd0);
    check("rst_if_data", bus.mc_if_data, 32'd0);
    check("rst_mem_rdata", bus.mc_mem_rdata, 32'd0);
    check("rst_ram_addr", 32'(bus.mc_ram_addr), 32'd0);
    check("rst_strobes", strobes(), 32'h1F);
    check_released("rst_bus_z");
    @(negedge clk);
    rst_n = 1'b1;

    // Step 1: fetch read of 0x10 -> halves 8 and 9, word 0xDEADBEEF in cycle L.
    preload(10'd8, 16'hBEEF);
    preload(10'd9, 16'hDEAD);
    @(negedge clk);
    bus.if_mc_addr = 32'h10; bus.if_mc_en = 1'b1;
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      if (c <= 2 * W + 2) begin
        check("t1_addr", 32'(bus.mc_ram_addr), (c <= W + 1) ? 32'd8 : 32'd9);
        check("t1_strobes", strobes(), 32'h10);
      end
      check("t1_ack", 32'(bus.mc_if_ack), 32'(c == L));
      if (bus.mc_if_ack) begin
        check("t1_data", bus.mc_if_data, 32'hDEADBEEF);
        bus.if_mc_en = 1'b0;
      end
    end
    exp_if_data = 32'hDEADBEEF; last_mem = 1'b0;

    // Step 2: memory write 0x12345678 to 0x20 -> halves 16/17, we_n low W cycles per half.
    check_released("t2_idle_z");
    bus.mem_mc_addr = 32'h20; bus.mem_mc_rw = 1'b1; bus.mem_mc_wdata = 32'h12345678; bus.mem_mc_en = 1'b1;
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      if (c <= 2 * W + 2) begin
        check("t2_addr", 32'(bus.mc_ram_addr), (c <= W + 1) ? 32'd16 : 32'd17);
        check("t2_strobes", strobes(), (c == 1 || c == W + 2) ? 32'h18 : 32'h08);
        check("t2_wdata", 32'(ram_data), (c <= W + 1) ? 32'h5678 : 32'h1234);
      end
      check("t2_ack", 32'(bus.mc_mem_ack), 32'(c == L));
      if (bus.mc_mem_ack) begin
        check("t2_rdata_held", bus.mc_mem_rdata, exp_mem_rdata);
        bus.mem_mc_en = 1'b0;
        check_released("t2_ack_z");
      end
    end
    ref_mem[16] = 16'h5678; ref_mem[17] = 16'h1234; last_mem = 1'b1;
    check("t2_sram16", 32'(sram[16]), 32'h5678);
    check("t2_sram17", 32'(sram[17]), 32'h1234);

    // Step 3: simultaneous requests, twice.
    run_round(1'b1, 1'b1, 32'h10, 32'h20, 1'b0, 32'd0);
    run_round(1'b1, 1'b1, 32'h24, 32'h28, 1'b0, 32'd0);

    // Step 4: reset during the HI phase of a write; no ack, then served fresh after release.
    bus.mem_mc_addr = 32'h40; bus.mem_mc_rw = 1'b1; bus.mem_mc_wdata = 32'hA5A55A5A; bus.mem_mc_en = 1'b1;
    for (int c = 1; c <= W + 2; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_strobes", strobes(), 32'h1F);
    check("t4_ram_addr", 32'(bus.mc_ram_addr), 32'd0);
    check_released("t4_bus_z");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t4_no_ack", 32'({bus.mc_if_ack, bus.mc_mem_ack}), 32'd0);
    end
    check("t4_if_data_rst", bus.mc_if_data, 32'd0);
    exp_if_data = 32'd0; exp_mem_rdata = 32'd0; last_mem = 1'b0;
    rst_n = 1'b1;
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      check("t4_ack", 32'(bus.mc_mem_ack), 32'(c == L));
      if (bus.mc_mem_ack) bus.mem_mc_en = 1'b0;
    end
    ref_mem[32] = 16'h5A5A; ref_mem[33] = 16'hA5A5; last_mem = 1'b1;
    check("t4_sram32", 32'(sram[32]), 32'h5A5A);
    check("t4_sram33", 32'(sram[33]), 32'hA5A5);

    // Step 6: back-to-back fetches, en dropped on each ack, new request in the following IDLE cycle.
    @(negedge clk);
    bus.if_mc_addr = 32'h10; bus.if_mc_en = 1'b1;
    for (int c = 1; c <= 2 * L + 3; c++) begin
      @(negedge clk);
      check("t6_ack", 32'(bus.mc_if_ack), 32'(c == L || c == 2 * L + 1));
      if (bus.mc_if_ack) begin
        check("t6_data", bus.mc_if_data, (c == L) ? word(32'h10) : word(32'h20));
        bus.if_mc_en = 1'b0;
      end
      if (c == L + 1) begin
        bus.if_mc_addr = 32'h20; bus.if_mc_en = 1'b1;
      end
    end
    bus.if_mc_en = 1'b0;
    exp_if_data = word(32'h20); last_mem = 1'b0;

    // Randomized rounds against the reference model.
    for (int r = 0; r < 40; r++) begin
      sel = int'($urandom_range(0, 2));
      rf = (sel != 1);
      rm = (sel != 0);
      run_round(rf, rm,
                {21'd0, 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3))},
                {21'd0, 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3))},
                1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
